// File: rtl/piece_queue_ctrl_pkg.sv
// Shared definitions for the piece queue controller: piece codes and FSM encoding.
package piece_queue_ctrl_pkg;

  localparam int PIECE_W = 3;

  localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd0;
  localparam logic [PIECE_W-1:0] PIECE_I    = 3'd1;
  localparam logic [PIECE_W-1:0] PIECE_O    = 3'd2;
  localparam logic [PIECE_W-1:0] PIECE_T    = 3'd3;
  localparam logic [PIECE_W-1:0] PIECE_J    = 3'd4;
  localparam logic [PIECE_W-1:0] PIECE_L    = 3'd5;
  localparam logic [PIECE_W-1:0] PIECE_S    = 3'd6;
  localparam logic [PIECE_W-1:0] PIECE_Z    = 3'd7;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_CAP   = 3'd1,
    ST_READY = 3'd2,
    ST_SPAWN = 3'd3,
    ST_HOLD  = 3'd4
  } pq_state_t;

endpackage

// File: rtl/piece_fifo_shift.sv
// Preview queue: entries are appended at the current count and leave from entry 0
// by shifting everything down one slot. Vacated slots read as PIECE_NONE.
module piece_fifo_shift
  import piece_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int W     = 3,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [W-1:0]       load_data,
  input  logic               shift,
  output logic [CW-1:0]      count,
  output logic [DEPTH*W-1:0] entries
);

  logic [W-1:0] q [DEPTH];

  // Queue storage and occupancy; a shift and a load never coincide, shift wins if they do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= W'(PIECE_NONE);
      count <= '0;
    end else if (shift) begin
      for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
      q[DEPTH-1] <= W'(PIECE_NONE);
      if (count != '0) count <= count - CW'(1);
    end else if (load && (count < CW'(DEPTH))) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count) q[i] <= load_data;
      end
      count <= count + CW'(1);
    end
  end

  // Flatten the queue with entry 0 in the least significant bits.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries[i*W +: W] = q[i];
  end

endmodule

// File: rtl/piece_queue_ctrl.sv
// Piece sequencer: keeps the preview queue topped up from the 7-bag generator,
// serves spawn requests and owns the hold slot with its once-per-piece lock.
module piece_queue_ctrl #(
  parameter int QUEUE_DEPTH = 3,
  parameter int PIECE_W     = piece_queue_ctrl_pkg::PIECE_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic                           gen_next,
  input  logic [PIECE_W-1:0]             gen_piece,
  input  logic                           spawn_req,
  output logic                           spawn_ack,
  output logic [PIECE_W-1:0]             spawn_piece,
  input  logic                           hold_req,
  input  logic [PIECE_W-1:0]             cur_piece,
  output logic                           hold_ack,
  output logic                           hold_nack,
  output logic [PIECE_W-1:0]             swap_piece,
  output logic [PIECE_W-1:0]             hold_piece,
  output logic [PIECE_W*QUEUE_DEPTH-1:0] preview,
  output logic                           ready
);
  import piece_queue_ctrl_pkg::*;

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  pq_state_t          state, state_n;
  logic               fifo_load, fifo_shift;
  logic [CW-1:0]      fifo_count;
  logic [PIECE_W-1:0] cap_data;
  logic [PIECE_W-1:0] head;
  logic               lock;

  piece_fifo_shift #(
    .DEPTH (QUEUE_DEPTH),
    .W     (PIECE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fifo_load),
    .load_data (cap_data),
    .shift     (fifo_shift),
    .count     (fifo_count),
    .entries   (preview)
  );

  assign head = preview[PIECE_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_REQ;
    else        state <= state_n;
  end

  // Next-state and strobe decode. gen_next is qualified by rst_n because the
  // reset state is REQ, yet no request may reach the generator while held in reset.
  always_comb begin
    state_n    = state;
    gen_next   = 1'b0;
    spawn_ack  = 1'b0;
    hold_ack   = 1'b0;
    hold_nack  = 1'b0;
    ready      = 1'b0;
    fifo_load  = 1'b0;
    fifo_shift = 1'b0;
    cap_data   = (gen_piece == '0) ? PIECE_W'(PIECE_I) : gen_piece;
    case (state)
      ST_REQ: begin
        gen_next = rst_n;
        state_n  = ST_CAP;
      end
      ST_CAP: begin
        fifo_load = 1'b1;
        state_n   = (fifo_count == CW'(QUEUE_DEPTH - 1)) ? ST_READY : ST_REQ;
      end
      ST_READY: begin
        ready = (fifo_count == CW'(QUEUE_DEPTH));
        if (spawn_req)     state_n = ST_SPAWN;
        else if (hold_req) state_n = ST_HOLD;
      end
      ST_SPAWN: begin
        spawn_ack  = 1'b1;
        fifo_shift = 1'b1;
        state_n    = ST_REQ;
      end
      ST_HOLD: begin
        if (lock) begin
          hold_nack = 1'b1;
          state_n   = ST_READY;
        end else if (hold_piece != '0) begin
          hold_ack = 1'b1;
          state_n  = ST_READY;
        end else begin
          hold_ack   = 1'b1;
          fifo_shift = 1'b1;
          state_n    = ST_REQ;
        end
      end
      default: state_n = ST_REQ;
    endcase
  end

  // Piece outputs are loaded on entry to SPAWN/HOLD so they are valid during the ack;
  // the hold slot and lock update on the way out of HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spawn_piece <= '0;
      swap_piece  <= '0;
      hold_piece  <= '0;
      lock        <= 1'b0;
    end else begin
      if (state == ST_READY && spawn_req) begin
        spawn_piece <= head;
      end
      if (state == ST_READY && !spawn_req && hold_req && !lock) begin
        swap_piece <= (hold_piece != '0) ? hold_piece : head;
      end
      if (state == ST_HOLD && !lock) begin
        hold_piece <= cur_piece;
        lock       <= 1'b1;
      end
      if (state == ST_SPAWN) begin
        lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Bench for piece_queue_ctrl: generator model feeds a scoreboard of expected queue contents.
module tb_piece_queue_ctrl;

  localparam int QD = 3;
  localparam int PW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            gen_next;
  logic [PW-1:0]   gen_piece;
  logic            spawn_req;
  logic            spawn_ack;
  logic [PW-1:0]   spawn_piece;
  logic            hold_req;
  logic [PW-1:0]   cur_piece;
  logic            hold_ack;
  logic            hold_nack;
  logic [PW-1:0]   swap_piece;
  logic [PW-1:0]   hold_piece;
  logic [PW*QD-1:0] preview;
  logic            ready;

  int tests_run    = 0;
  int tests_failed = 0;

  int gen_list[$];   // pieces the generator model will hand out
  int exp_q[$];      // scoreboard: expected queue contents, entry 0 first
  int hold_m = 0;    // expected hold slot
  int gv;

  piece_queue_ctrl #(.QUEUE_DEPTH(QD), .PIECE_W(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gen_next    (gen_next),
    .gen_piece   (gen_piece),
    .spawn_req   (spawn_req),
    .spawn_ack   (spawn_ack),
    .spawn_piece (spawn_piece),
    .hold_req    (hold_req),
    .cur_piece   (cur_piece),
    .hold_ack    (hold_ack),
    .hold_nack   (hold_nack),
    .swap_piece  (swap_piece),
    .hold_piece  (hold_piece),
    .preview     (preview),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  // Generator model: registered output the cycle after gen_next; pushes what the queue should capture.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_piece <= '0;
    end else if (gen_next) begin
      gv = (gen_list.size() != 0) ? gen_list.pop_front() : 1;
      gen_piece <= PW'(gv);
      exp_q.push_back((gv == 0) ? 1 : gv);
    end
  end

  function automatic logic [PW*QD-1:0] pack_model();
    logic [PW*QD-1:0] r;
    r = '0;
    for (int i = 0; i < QD; i++) begin
      if (i < exp_q.size()) r[i*PW +: PW] = PW'(exp_q[i]);
    end
    return r;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int pulses;
    int rdy_cyc;
    rst_n = 1'b0; spawn_req = 1'b0; hold_req = 1'b0; cur_piece = '0;
    gen_list.delete(); exp_q.delete(); hold_m = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (gen_next !== 1'b0) begin tests_failed++; $display("FAIL reset_gen_next: got %0d want 0", gen_next); end
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %0d want 0", ready); end
    tests_run++;
    if ({spawn_ack, hold_ack, hold_nack} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_acks: got %b want 000", {spawn_ack, hold_ack, hold_nack});
    end
    tests_run++;
    if ({spawn_piece, swap_piece, hold_piece} !== '0) begin
      tests_failed++; $display("FAIL reset_pieces: got %0d/%0d/%0d want 0", spawn_piece, swap_piece, hold_piece);
    end
    tests_run++;
    if (preview !== '0) begin tests_failed++; $display("FAIL reset_preview: got %h want 0", preview); end

    gen_list = '{3, 5, 2};
    rst_n = 1'b1;
    #1;
    pulses  = gen_next ? 1 : 0;
    rdy_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (gen_next) pulses++;
      if (ready && rdy_cyc < 0) rdy_cyc = c;
    end
    tests_run++;
    if (pulses != 3) begin tests_failed++; $display("FAIL fill_gen_pulses: got %0d want 3", pulses); end
    tests_run++;
    if (rdy_cyc != 6) begin tests_failed++; $display("FAIL fill_ready_cycle: got %0d want 6", rdy_cyc); end
    tests_run++;
    if (preview !== {3'd2, 3'd5, 3'd3}) begin
      tests_failed++; $display("FAIL fill_preview: got %h want %h", preview, {3'd2, 3'd5, 3'd3});
    end
    tests_run++;
    if (preview !== pack_model()) begin
      tests_failed++; $display("FAIL fill_scoreboard: got %h want %h", preview, pack_model());
    end
  endtask

  task automatic test_spawn();
    bit ok;
    int exp;
    wait_ready(ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL spawn_wait_ready: got timeout want ready"); end
    gen_list.push_back(7);
    spawn_req = 1'b1;
    @(negedge clk);
    tests_run++;
    if (spawn_ack !== 1'b1) begin tests_failed++; $display("FAIL spawn_ack: got %0d want 1", spawn_ack); end
    exp = exp_q.pop_front();
    tests_run++;
    if (spawn_piece !== PW'(exp)) begin tests_failed++; $display("FAIL spawn_piece: got %0d want %0d", spawn_piece, exp); end
    spawn_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({spawn_ack, ready} !== 2'b00) begin
      tests_failed++; $display("FAIL spawn_ack_plus1: got ack=%0d ready=%0d want 0/0", spawn_ack, ready);
    end
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL spawn_ready_plus2: got %0d want 0", ready); end
    @(negedge clk);
    tests_run++;
    if (ready !== 1'b1) begin tests_failed++; $display("FAIL spawn_ready_plus3: got %0d want 1", ready); end
    tests_run++;
    if (preview !== {3'd7, 3'd2, 3'd5} || preview !== pack_model()) begin
      tests_failed++; $display("FAIL spawn_refill_preview: got %h want %h", preview, pack_model());
    end
    tests_run++;
    if (spawn_piece !== PW'(exp)) begin tests_failed++; $display("FAIL spawn_piece_held: got %0d want %0d", spawn_piece, exp); end
  endtask

  task automatic test_hold();
    bit ok;
    int exp;
    cur_piece = 3'd4;
    gen_list.push_back(1);
    hold_req = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({hold_ack, hold_nack} !== 2'b10) begin
      tests_failed++; $display("FAIL hold_empty_ack: got ack=%0d nack=%0d want 1/0", hold_ack, hold_nack);
    end
    exp = exp_q.pop_front();
    tests_run++;
    if (swap_piece !== PW'(exp)) begin tests_failed++; $display("FAIL hold_empty_swap: got %0d want %0d", swap_piece, exp); end
    hold_req = 1'b0;
    hold_m = 4;
    @(negedge clk);
    tests_run++;
    if (hold_piece !== PW'(hold_m)) begin tests_failed++; $display("FAIL hold_slot: got %0d want %0d", hold_piece, hold_m); end
    wait_ready(ok);
    tests_run++;
    if (!ok || preview !== pack_model()) begin
      tests_failed++; $display("FAIL hold_refill: got ready=%0d preview=%h want 1/%h", ready, preview, pack_model());
    end
    hold_req = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({hold_ack, hold_nack} !== 2'b01) begin
      tests_failed++; $display("FAIL hold_locked_nack: got ack=%0d nack=%0d want 0/1", hold_ack, hold_nack);
    end
    hold_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (hold_piece !== PW'(hold_m) || ready !== 1'b1) begin
      tests_failed++; $display("FAIL hold_locked_keep: got hold=%0d ready=%0d want %0d/1", hold_piece, ready, hold_m);
    end
    tests_run++;
    if (swap_piece !== PW'(exp)) begin tests_failed++; $display("FAIL hold_swap_held: got %0d want %0d", swap_piece, exp); end
  endtask

  task automatic test_swap_after_spawn();
    bit ok;
    int exp;
    logic [PW*QD-1:0] prev;
    gen_list.push_back(3);
    spawn_req = 1'b1;
    @(negedge clk);
    exp = exp_q.pop_front();
    tests_run++;
    if (spawn_ack !== 1'b1 || spawn_piece !== PW'(exp)) begin
      tests_failed++; $display("FAIL swap_spawn: got ack=%0d piece=%0d want 1/%0d", spawn_ack, spawn_piece, exp);
    end
    spawn_req = 1'b0;
    wait_ready(ok);
    prev = pack_model();
    tests_run++;
    if (!ok || preview !== prev) begin
      tests_failed++; $display("FAIL swap_refill: got ready=%0d preview=%h want 1/%h", ready, preview, prev);
    end
    cur_piece = 3'd6;
    hold_req  = 1'b1;
    @(negedge clk);
    tests_run++;
    if (hold_ack !== 1'b1 || swap_piece !== PW'(hold_m)) begin
      tests_failed++; $display("FAIL swap_ack: got ack=%0d swap=%0d want 1/%0d", hold_ack, swap_piece, hold_m);
    end
    hold_req = 1'b0;
    hold_m   = 6;
    @(negedge clk);
    tests_run++;
    if (hold_piece !== PW'(hold_m)) begin tests_failed++; $display("FAIL swap_hold_slot: got %0d want %0d", hold_piece, hold_m); end
    tests_run++;
    if (preview !== prev || ready !== 1'b1) begin
      tests_failed++; $display("FAIL swap_preview_kept: got %h ready=%0d want %h/1", preview, ready, prev);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int exp;
    int acks;
    int nacks;
    gen_list.push_back(4);
    cur_piece = 3'd2;
    spawn_req = 1'b1;
    hold_req  = 1'b1;
    @(negedge clk);
    exp = exp_q.pop_front();
    tests_run++;
    if ({spawn_ack, hold_ack, hold_nack} !== 3'b100 || spawn_piece !== PW'(exp)) begin
      tests_failed++;
      $display("FAIL b2b_spawn_first: got acks=%b piece=%0d want 100/%0d", {spawn_ack, hold_ack, hold_nack}, spawn_piece, exp);
    end
    spawn_req = 1'b0;
    acks  = 0;
    nacks = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (hold_ack) begin
        acks++;
        tests_run++;
        if (swap_piece !== PW'(hold_m)) begin
          tests_failed++; $display("FAIL b2b_swap: got %0d want %0d", swap_piece, hold_m);
        end
        hold_req = 1'b0;
      end
      if (hold_nack) begin
        nacks++;
        hold_req = 1'b0;
      end
    end
    hold_req = 1'b0;
    hold_m   = 2;
    tests_run++;
    if (acks != 1 || nacks != 0) begin
      tests_failed++; $display("FAIL b2b_hold_count: got ack=%0d nack=%0d want 1/0", acks, nacks);
    end
    tests_run++;
    if (hold_piece !== PW'(hold_m)) begin tests_failed++; $display("FAIL b2b_hold_slot: got %0d want %0d", hold_piece, hold_m); end
    wait_ready(ok);
    tests_run++;
    if (!ok || preview !== pack_model()) begin
      tests_failed++; $display("FAIL b2b_preview: got ready=%0d preview=%h want 1/%h", ready, preview, pack_model());
    end
  endtask

  task automatic test_reset_mid_cap();
    bit ok;
    int exp;
    gen_list.push_back(5);
    spawn_req = 1'b1;
    @(negedge clk);
    exp = exp_q.pop_front();
    tests_run++;
    if (spawn_ack !== 1'b1 || spawn_piece !== PW'(exp)) begin
      tests_failed++; $display("FAIL rst_spawn: got ack=%0d piece=%0d want 1/%0d", spawn_ack, spawn_piece, exp);
    end
    spawn_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (gen_next !== 1'b1) begin tests_failed++; $display("FAIL rst_req_pulse: got %0d want 1", gen_next); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({gen_next, ready, spawn_ack, hold_ack, hold_nack} !== 5'b0) begin
      tests_failed++; $display("FAIL rst_mid_strobes: got %b want 00000", {gen_next, ready, spawn_ack, hold_ack, hold_nack});
    end
    tests_run++;
    if (preview !== '0 || {spawn_piece, swap_piece, hold_piece} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_data: got preview=%h pieces=%0d/%0d/%0d want 0", preview, spawn_piece, swap_piece, hold_piece);
    end
    exp_q.delete();
    gen_list.delete();
    hold_m = 0;
    @(negedge clk);
    gen_list = '{6, 0, 7};
    rst_n = 1'b1;
    wait_ready(ok);
    tests_run++;
    if (!ok || preview !== {3'd7, 3'd1, 3'd6} || preview !== pack_model()) begin
      tests_failed++; $display("FAIL rst_refill: got ready=%0d preview=%h want 1/%h", ready, preview, {3'd7, 3'd1, 3'd6});
    end
    tests_run++;
    if (hold_piece !== PW'(hold_m)) begin tests_failed++; $display("FAIL rst_hold_empty: got %0d want %0d", hold_piece, hold_m); end
    spawn_req = 1'b1;
    @(negedge clk);
    exp = exp_q.pop_front();
    tests_run++;
    if (spawn_ack !== 1'b1 || spawn_piece !== PW'(exp)) begin
      tests_failed++; $display("FAIL rst_first_spawn: got ack=%0d piece=%0d want 1/%0d", spawn_ack, spawn_piece, exp);
    end
    spawn_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    spawn_req = 1'b0;
    hold_req  = 1'b0;
    cur_piece = '0;
    test_reset();
    test_spawn();
    test_hold();
    test_swap_after_spawn();
    test_back_to_back();
    test_reset_mid_cap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
